tile_engine: RTL and testbench

Parametrised next-generation tile processor for the NPU datapath. On `start` it walks one TILE×TILE output tile of a MAT_DIM×MAT_DIM signed int matrix C, reading operands from SRAM A/B and writing results to SRAM C. Compared with the previous tile processor it adds:
- configurable tile, matrix and data widths;
- configurable SRAM read latency;
- element-wise ADD/SUB/MUL/MAX plus a full tile MATMUL (K = MAT_DIM);
- run-time output shift and saturation;
- `busy` and `err` status outputs.

---
 rtl/tile_engine_pkg.sv | 45 ++++
 rtl/tile_engine_if.sv | 37 +++
 rtl/tile_mac_unit.sv | 75 +++++++
 rtl/tile_engine.sv | 171 +++++++++++++++++
 tb/tb_tile_engine.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tile_engine_pkg.sv
// Shared types and helpers for the tile engine: op codes, FSM states and the
// shift-then-saturate function used by the arithmetic stage.
package tile_pkg;

    typedef enum logic [2:0] {
        OpMul    = 3'd0,
        OpAdd    = 3'd1,
        OpSub    = 3'd2,
        OpMax    = 3'd3,
        OpMatmul = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_e;

    localparam int unsigned SatW = 64;

    function automatic logic op_legal(input logic [2:0] code);
        return code <= 3'd4;
    endfunction

    // Arithmetic right shift, then clamp to a signed dw-bit range.
    function automatic logic signed [SatW-1:0] sat_dw(input logic signed [SatW-1:0] acc,
                                                      input logic [4:0] shift,
                                                      input int unsigned dw);
        logic signed [SatW-1:0] val;
        logic signed [SatW-1:0] hi;
        logic signed [SatW-1:0] lo;
        val = acc >>> shift;
        hi  = 64'sd1 <<< (dw - 1);
        hi  = hi - 64'sd1;
        lo  = -hi - 64'sd1;
        if (val > hi) begin
            val = hi;
        end else if (val < lo) begin
            val = lo;
        end
        return val;
    endfunction

endpackage

// File: rtl/tile_engine_if.sv
// Host control, status and SRAM A/B/C signals of the tile engine; the engine
// connects through the slave modport, the host/SRAM side through master.
interface tile_engine_if #(
    parameter int unsigned MAT_DIM = 32,
    parameter int unsigned TILE    = 4,
    parameter int unsigned DW      = 8
);
    localparam int unsigned AW  = $clog2(MAT_DIM * MAT_DIM);
    localparam int unsigned TIW = $clog2(MAT_DIM / TILE);

    logic                  start;
    logic [TIW-1:0]        tile_i;
    logic [TIW-1:0]        tile_j;
    logic [2:0]            op_code;
    logic [4:0]            out_shift;
    logic [AW-1:0]         sram_A_addr;
    logic signed [DW-1:0]  sram_A_dout;
    logic [AW-1:0]         sram_B_addr;
    logic signed [DW-1:0]  sram_B_dout;
    logic                  sram_C_we;
    logic [AW-1:0]         sram_C_addr;
    logic signed [DW-1:0]  sram_C_din;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start, tile_i, tile_j, op_code, out_shift, sram_A_dout, sram_B_dout,
        input  sram_A_addr, sram_B_addr, sram_C_we, sram_C_addr, sram_C_din, busy, done, err
    );

    modport slave (
        input  start, tile_i, tile_j, op_code, out_shift, sram_A_dout, sram_B_dout,
        output sram_A_addr, sram_B_addr, sram_C_we, sram_C_addr, sram_C_din, busy, done, err
    );

endinterface

// File: rtl/tile_mac_unit.sv
// Arithmetic stage: element-wise ops or multiply-accumulate over k, then
// shift and saturate; registers one C write per last-k beat.
module tile_mac_unit
    import tile_pkg::*;
#(
    parameter int unsigned DW   = 8,
    parameter int unsigned ACCW = 24,
    parameter int unsigned AW   = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_i,
    input  logic                 first_i,
    input  logic                 last_i,
    input  op_e                  op_i,
    input  logic [4:0]           shift_i,
    input  logic [AW-1:0]        caddr_i,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [DW-1:0] b_i,
    output logic                 we_o,
    output logic [AW-1:0]        addr_o,
    output logic signed [DW-1:0] din_o
);

    logic signed [ACCW-1:0] a_x, b_x, prod, sum, val, acc_q, acc_d;
    logic [4:0]             sh;
    logic                   we_q, we_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic signed [DW-1:0]   din_q, din_d;

    always_comb begin
        a_x  = {{(ACCW-DW){a_i[DW-1]}}, a_i};
        b_x  = {{(ACCW-DW){b_i[DW-1]}}, b_i};
        prod = a_x * b_x;
        sum  = prod;
        if (!first_i) begin
            sum = acc_q + prod;
        end
        acc_d = acc_q;
        if (valid_i) begin
            acc_d = sum;
        end
        val = prod;
        sh  = shift_i;
        case (op_i)
            OpAdd:    begin val = a_x + b_x;                  sh = '0; end
            OpSub:    begin val = a_x - b_x;                  sh = '0; end
            OpMax:    begin val = (a_x > b_x) ? a_x : b_x;    sh = '0; end
            OpMatmul: val = sum;
            default:  val = prod;
        endcase
        we_d   = valid_i & last_i;
        addr_d = caddr_i;
        din_d  = DW'(sat_dw({{(SatW-ACCW){val[ACCW-1]}}, val}, sh, DW));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            din_q  <= din_d;
        end
    end

    assign we_o   = we_q;
    assign addr_o = addr_q;
    assign din_o  = din_q;

endmodule

// File: rtl/tile_engine.sv
// Tile processor top: walks one TILE x TILE output tile, issuing one A/B read
// pair per cycle and tagging each through an RD_LAT-deep pipe to the MAC stage.
module tile_engine
    import tile_pkg::*;
#(
    parameter int unsigned MAT_DIM = 32,
    parameter int unsigned TILE    = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned ACCW    = 24,
    parameter int unsigned RD_LAT  = 1
) (
    input logic         clk,
    input logic         rst_n,
    tile_engine_if.slave bus
);

    localparam int unsigned AW  = $clog2(MAT_DIM * MAT_DIM);
    localparam int unsigned TIW = $clog2(MAT_DIM / TILE);
    localparam int unsigned TCW = $clog2(TILE);
    localparam int unsigned KW  = $clog2(MAT_DIM);

    state_e          state_q, state_d;
    logic [TIW-1:0]  ti_q, ti_d, tj_q, tj_d;
    op_e             op_q, op_d;
    logic [4:0]      shift_q, shift_d;
    logic            err_q, err_d;
    logic [TCW-1:0]  r_q, r_d, c_q, c_d;
    logic [KW-1:0]   k_q, k_d;
    logic            mm, last_k, last_pair, issue;
    logic [AW-1:0]   c_addr;

    logic [RD_LAT-1:0] pv_q, pf_q, pl_q;
    logic [AW-1:0]     pa_q [RD_LAT];

    // Power-of-two sizes make row*MAT_DIM + col a plain concatenation.
    always_comb begin
        mm        = (op_q == OpMatmul);
        last_k    = !mm || (k_q == KW'(MAT_DIM - 1));
        last_pair = last_k && (r_q == TCW'(TILE - 1)) && (c_q == TCW'(TILE - 1));
        issue     = (state_q == StIssue);
        c_addr    = {ti_q, r_q, tj_q, c_q};
    end

    assign bus.sram_A_addr = mm ? {ti_q, r_q, k_q} : c_addr;
    assign bus.sram_B_addr = mm ? {k_q, tj_q, c_q} : c_addr;
    assign bus.busy        = (state_q == StIssue) || (state_q == StDrain);
    assign bus.done        = (state_q == StDone);
    assign bus.err         = (state_q == StDone) && err_q;

    always_comb begin
        state_d = state_q;
        ti_d    = ti_q;
        tj_d    = tj_q;
        op_d    = op_q;
        shift_d = shift_q;
        err_d   = err_q;
        r_d     = r_q;
        c_d     = c_q;
        k_d     = k_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (op_legal(bus.op_code)) begin
                        state_d = StIssue;
                        ti_d    = bus.tile_i;
                        tj_d    = bus.tile_j;
                        op_d    = op_e'(bus.op_code);
                        shift_d = bus.out_shift;
                        err_d   = 1'b0;
                        r_d     = '0;
                        c_d     = '0;
                        k_d     = '0;
                    end else begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end
                end
            end
            StIssue: begin
                if (last_pair) begin
                    state_d = StDrain;
                end else if (last_k) begin
                    k_d = '0;
                    if (c_q == TCW'(TILE - 1)) begin
                        c_d = '0;
                        r_d = r_q + 1'b1;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDrain: begin
                // Pipe empty means the final result is on the C port this cycle.
                if (pv_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ti_q    <= '0;
            tj_q    <= '0;
            op_q    <= OpMul;
            shift_q <= '0;
            err_q   <= 1'b0;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            ti_q    <= ti_d;
            tj_q    <= tj_d;
            op_q    <= op_d;
            shift_q <= shift_d;
            err_q   <= err_d;
            r_q     <= r_d;
            c_q     <= c_d;
            k_q     <= k_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q <= '0;
            pf_q <= '0;
            pl_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pa_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= issue;
            pf_q[0] <= (k_q == '0);
            pl_q[0] <= last_k;
            pa_q[0] <= c_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pf_q[i] <= pf_q[i-1];
                pl_q[i] <= pl_q[i-1];
                pa_q[i] <= pa_q[i-1];
            end
        end
    end

    tile_mac_unit #(
        .DW   (DW),
        .ACCW (ACCW),
        .AW   (AW)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (pv_q[RD_LAT-1]),
        .first_i (pf_q[RD_LAT-1]),
        .last_i  (pl_q[RD_LAT-1]),
        .op_i    (op_q),
        .shift_i (shift_q),
        .caddr_i (pa_q[RD_LAT-1]),
        .a_i     (bus.sram_A_dout),
        .b_i     (bus.sram_B_dout),
        .we_o    (bus.sram_C_we),
        .addr_o  (bus.sram_C_addr),
        .din_o   (bus.sram_C_din)
    );

endmodule

// File: tb/tb_tile_engine.sv
// Directed bench for tile_engine: two instances (RD_LAT 1 and 3) sharing an A/B
// SRAM model; cycle 1 is the cycle that begins at the edge sampling start.
module tb_tile_engine;

    localparam int unsigned MD = 32;
    localparam int unsigned TL = 4;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tile_engine_if #(.MAT_DIM(MD), .TILE(TL), .DW(DW)) if1 ();
    tile_engine_if #(.MAT_DIM(MD), .TILE(TL), .DW(DW)) if3 ();

    tile_engine #(.MAT_DIM(MD), .TILE(TL), .DW(DW), .ACCW(24), .RD_LAT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    tile_engine #(.MAT_DIM(MD), .TILE(TL), .DW(DW), .ACCW(24), .RD_LAT(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3)
    );

    logic signed [DW-1:0] mem_a [1024];
    logic signed [DW-1:0] mem_b [1024];
    logic signed [DW-1:0] a1, b1;
    logic signed [DW-1:0] a3 [3];
    logic signed [DW-1:0] b3 [3];

    always @(posedge clk) begin
        a1    <= mem_a[if1.sram_A_addr];
        b1    <= mem_b[if1.sram_B_addr];
        a3[0] <= mem_a[if3.sram_A_addr];
        b3[0] <= mem_b[if3.sram_B_addr];
        a3[1] <= a3[0];
        b3[1] <= b3[0];
        a3[2] <= a3[1];
        b3[2] <= b3[1];
    end

    assign if1.sram_A_dout = a1;
    assign if1.sram_B_dout = b1;
    assign if3.sram_A_dout = a3[2];
    assign if3.sram_B_dout = b3[2];

    bit                   sel;
    logic                 m_we, m_busy, m_done, m_err;
    logic [9:0]           m_caddr;
    logic signed [DW-1:0] m_din;

    assign m_we    = sel ? if3.sram_C_we   : if1.sram_C_we;
    assign m_busy  = sel ? if3.busy        : if1.busy;
    assign m_done  = sel ? if3.done        : if1.done;
    assign m_err   = sel ? if3.err         : if1.err;
    assign m_caddr = sel ? if3.sram_C_addr : if1.sram_C_addr;
    assign m_din   = sel ? if3.sram_C_din  : if1.sram_C_din;

    integer mem_c [1024];
    int n_cmp, n_fail;
    int cyc, wr_cnt, first_addr, last_addr, first_wr_cyc, done_cyc, done_cnt, busy_cnt, err_cnt;

    task automatic check(input string tag, input integer obs, input integer exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        cyc = 0; wr_cnt = 0; first_addr = -1; last_addr = -1; first_wr_cyc = 0;
        done_cyc = 0; done_cnt = 0; busy_cnt = 0; err_cnt = 0;
        for (int i = 0; i < 1024; i++) mem_c[i] = -999;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (m_we) begin
            wr_cnt++;
            if (wr_cnt == 1) begin
                first_addr   = int'(m_caddr);
                first_wr_cyc = cyc;
            end
            last_addr      = int'(m_caddr);
            mem_c[m_caddr] = m_din;
        end
        if (m_done && done_cyc == 0) done_cyc = cyc;
        if (m_done) done_cnt++;
        if (m_busy) busy_cnt++;
        if (m_err)  err_cnt++;
    endtask

    task automatic launch(input bit s, input int op, input int ti, input int tj, input int sh);
        @(negedge clk);
        sel = s;
        if (s) begin
            if3.op_code = 3'(op); if3.tile_i = 3'(ti); if3.tile_j = 3'(tj);
            if3.out_shift = 5'(sh); if3.start = 1'b1;
        end else begin
            if1.op_code = 3'(op); if1.tile_i = 3'(ti); if1.tile_j = 3'(tj);
            if1.out_shift = 5'(sh); if1.start = 1'b1;
        end
        @(posedge clk);
        #1;
        if1.start = 1'b0;
        if3.start = 1'b0;
        clear_stats();
    endtask

    task automatic run_done(input int limit);
        while (done_cyc == 0 && cyc < limit) step();
        step();
    endtask

    task automatic check_run(input string tag, input int exp_done, input int exp_first_wc);
        check({tag, "_done_cycle"}, done_cyc, exp_done);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_busy_cycles"}, busy_cnt, exp_done - 1);
        check({tag, "_err"}, err_cnt, 0);
        check({tag, "_writes"}, wr_cnt, 16);
        check({tag, "_first_wr_cycle"}, first_wr_cyc, exp_first_wc);
    endtask

    task automatic check_tile(input string tag, input int r0, input int c0, input int v,
                              input bit ramp);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("%s_c[%0d][%0d]", tag, r, c), mem_c[(r0 + r) * 32 + c0 + c],
                      ramp ? r + c : v);
            end
        end
    endtask

    task automatic fill(input int av, input int bv);
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 8'(av);
            mem_b[i] = 8'(bv);
        end
    endtask

    task automatic fill_matmul();
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = ((i / 32) == (i % 32)) ? 8'sd1 : 8'sd0;
            mem_b[i] = 8'(((i / 32) + (i % 32)) % 64);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; sel = 1'b0;
        rst_n = 1'b0;
        if1.start = 1'b0; if1.tile_i = '0; if1.tile_j = '0; if1.op_code = '0; if1.out_shift = '0;
        if3.start = 1'b0; if3.tile_i = '0; if3.tile_j = '0; if3.op_code = '0; if3.out_shift = '0;
        clear_stats();
        fill(0, 0);
        #12;
        check("rst_busy", if1.busy, 0);
        check("rst_done", if1.done, 0);
        check("rst_err", if1.err, 0);
        check("rst_we", if1.sram_C_we, 0);
        check("rst_a_addr", if1.sram_A_addr, 0);
        check("rst_b_addr", if1.sram_B_addr, 0);
        check("rst_c_addr", if1.sram_C_addr, 0);
        check("rst_c_din", if1.sram_C_din, 0);
        check("rst3_busy", if3.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ADD saturates 150 to 127; tile origin (4,8)
        fill(100, 50);
        launch(0, 1, 1, 2, 0);
        run_done(100);
        check_run("add", 19, 3);
        check("add_first_addr", first_addr, 136);
        check("add_last_addr", last_addr, 235);
        check_tile("add", 4, 8, 127, 0);

        fill(-100, 100);
        launch(0, 2, 3, 3, 0);
        run_done(100);
        check_run("sub", 19, 3);
        check_tile("sub", 12, 12, -128, 0);

        // MAX ignores the nonzero shift
        fill(-5, 7);
        launch(0, 3, 3, 3, 9);
        run_done(100);
        check_run("max", 19, 3);
        check_tile("max", 12, 12, 7, 0);

        // 200 >>> 4 = 12
        fill(20, 10);
        launch(0, 0, 2, 1, 4);
        run_done(100);
        check_run("mul", 19, 3);
        check_tile("mul", 8, 4, 12, 0);
        launch(1, 0, 2, 1, 4);
        run_done(100);
        check_run("mul_lat3", 21, 5);
        check_tile("mul_lat3", 8, 4, 12, 0);

        // identity x B gives B[r][c] = r+c; first result after 32 k beats
        fill_matmul();
        launch(0, 4, 0, 0, 0);
        run_done(1000);
        check_run("mm", 515, 34);
        check("mm_first_addr", first_addr, 0);
        check("mm_last_addr", last_addr, 99);
        check_tile("mm", 0, 0, 0, 1);

        // illegal op: immediate done+err, no SRAM activity, addresses hold
        launch(0, 6, 1, 1, 0);
        run_done(20);
        check("ill_done_cycle", done_cyc, 1);
        check("ill_done_pulses", done_cnt, 1);
        check("ill_err", err_cnt, 1);
        check("ill_busy", busy_cnt, 0);
        check("ill_writes", wr_cnt, 0);
        check("ill_a_addr", if1.sram_A_addr, 127);
        check("ill_b_addr", if1.sram_B_addr, 995);
        fill(1, 2);
        launch(0, 1, 0, 1, 0);
        run_done(100);
        check_run("post_ill", 19, 3);
        check_tile("post_ill", 0, 4, 3, 0);

        // start re-pulsed mid-MATMUL with different operands must be ignored
        fill_matmul();
        launch(0, 4, 0, 0, 0);
        while (cyc < 99) step();
        if1.op_code = 3'd1; if1.tile_i = 3'd7; if1.tile_j = 3'd7; if1.start = 1'b1;
        step();
        if1.start = 1'b0;
        check("pulse_a_addr", if1.sram_A_addr, 3);
        check("pulse_b_addr", if1.sram_B_addr, 99);
        run_done(1000);
        check_run("mm_pulse", 515, 34);
        check_tile("mm_pulse", 0, 0, 0, 1);

        // reset lands on the write of output 5 (cycle 32*5+34)
        launch(0, 4, 0, 0, 0);
        while (cyc < 194) step();
        check("pre_rst_we", m_we, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", if1.busy, 0);
        check("mid_rst_we", if1.sram_C_we, 0);
        check("mid_rst_a_addr", if1.sram_A_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        repeat (600) step();
        check("post_rst_done", done_cnt, 0);
        check("post_rst_writes", wr_cnt, 0);
        check("post_rst_busy", busy_cnt, 0);
        fill(3, -4);
        launch(0, 1, 2, 2, 0);
        run_done(100);
        check_run("post_rst_add", 19, 3);
        check_tile("post_rst_add", 8, 8, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
